// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM states, access lengths, bus widths
// and the pipeline stall bus.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LEN_W  = 2;
  localparam int unsigned CNT_W  = 3;

  localparam logic [CNT_W-1:0] FETCH_N = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  typedef enum logic [LEN_W-1:0] {
    LEN_BYTE = 2'd0,
    LEN_HALF = 2'd1,
    LEN_WORD = 2'd3
  } mem_len_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

  typedef struct packed {
    logic if_stall;
    logic mem_stall;
  } stall_bus_t;

  // Byte count for a mem_len code; the illegal code 2 is treated as a word.
  function automatic logic [CNT_W-1:0] len_to_n(input logic [LEN_W-1:0] len);
    case (mem_len_e'(len))
      LEN_BYTE: return 3'd1;
      LEN_HALF: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Byte-serial RAM arbiter between instruction fetch and the MEM stage; MEM has
// priority, transactions are never preempted, rdy=0 freezes everything.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_data,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [LEN_W-1:0]  mem_len,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  input  logic [BYTE_W-1:0] ram_din,
  output logic [BYTE_W-1:0] ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic              if_stall_req,
  output logic              mem_stall_req
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;

  logic [1:0]        rd_lane;
  logic [1:0]        wr_lane;
  logic [ADDR_W-1:0] cur_addr;
  stall_bus_t        stall;

  // Read data arrives one cycle after its address, so cnt=i fills lane i-1.
  assign rd_lane  = 2'(cnt_q - 3'd1);
  assign wr_lane  = cnt_q[1:0];
  assign cur_addr = base_q + ADDR_W'(cnt_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      cnt_q       <= '0;
      n_q         <= '0;
      base_q      <= '0;
      wdata_q     <= '0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = if_done_q;
    mem_done_d  = mem_done_q;
    ram_a       = '0;
    ram_dout    = '0;
    ram_wr      = 1'b0;

    case (state_q)
      ST_READ: begin
        if (cnt_q < n_q) ram_a = cur_addr;
      end
      ST_WRITE: begin
        ram_a    = cur_addr;
        ram_dout = wdata_q[{wr_lane, 3'b000} +: BYTE_W];
        ram_wr   = rdy;
      end
      default: ;
    endcase

    if (rdy) begin
      if_done_d  = 1'b0;
      mem_done_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Nothing is accepted in a done cycle, so the requester can drop req first.
          if (!if_done_q && !mem_done_q) begin
            if (mem_req) begin
              base_d  = mem_addr;
              n_d     = len_to_n(mem_len);
              wdata_d = mem_wdata;
              owner_d = OWN_MEM;
              cnt_d   = '0;
              if (mem_we) begin
                state_d = ST_WRITE;
              end else begin
                state_d     = ST_READ;
                mem_rdata_d = '0;
              end
            end else if (if_req) begin
              base_d    = if_addr;
              n_d       = FETCH_N;
              owner_d   = OWN_IF;
              cnt_d     = '0;
              state_d   = ST_READ;
              if_data_d = '0;
            end
          end
        end
        ST_READ: begin
          if (cnt_q != '0) begin
            if (owner_q == OWN_MEM) mem_rdata_d[{rd_lane, 3'b000} +: BYTE_W] = ram_din;
            else                    if_data_d[{rd_lane, 3'b000} +: BYTE_W]   = ram_din;
          end
          if (cnt_q == n_q) begin
            state_d = ST_IDLE;
            if (owner_q == OWN_MEM) mem_done_d = 1'b1;
            else                    if_done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        ST_WRITE: begin
          if (cnt_q == n_q - 3'd1) begin
            state_d    = ST_IDLE;
            mem_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign stall.if_stall  = if_req & ~if_done_q;
  assign stall.mem_stall = mem_req & ~mem_done_q;

  assign if_stall_req  = stall.if_stall;
  assign mem_stall_req = stall.mem_stall;
  assign if_data       = if_data_q;
  assign if_done       = if_done_q;
  assign mem_rdata     = mem_rdata_q;
  assign mem_done      = mem_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected done pulses and RAM writes are queued
// when a request is raised and checked when the DUT produces them.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic        if_done;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [1:0]  mem_len;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic [7:0]  ram_din, ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic        if_stall_req, mem_stall_req;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [31:0] data;
    int          due;
    bit          has_data;
  } done_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
    int          due;
  } wr_t;

  done_t exp_if_q[$];
  done_t exp_mem_q[$];
  wr_t   exp_wr_q[$];
  done_t mon_d;
  wr_t   mon_w;
  bit    due_if, due_mem;

  logic [7:0] ram [512];

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_len(mem_len),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr),
    .if_stall_req(if_stall_req), .mem_stall_req(mem_stall_req)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM, 9 address bits decoded; it is frozen by rdy like the rest of the system.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 512; i++) ram[i] <= 8'h00;
      ram[9'h100] <= 8'h13;
      ram[9'h101] <= 8'h00;
      ram[9'h102] <= 8'h00;
      ram[9'h103] <= 8'h93;
      ram[9'h040] <= 8'h5A;
      ram[9'h1FF] <= 8'hCD;
      ram[9'h000] <= 8'hAB;
    end else if (rdy) begin
      ram_din <= ram[ram_a[8:0]];
      if (ram_wr) ram[ram_a[8:0]] <= ram_dout;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor: stall lines, rdy gating of writes, RAM writes and done pulses.
  always @(negedge clk) begin
    due_if  = (exp_if_q.size() != 0) && (exp_if_q[0].due == cyc);
    due_mem = (exp_mem_q.size() != 0) && (exp_mem_q[0].due == cyc);
    chk("if_stall_req", 32'(if_stall_req), 32'(if_req && !due_if));
    chk("mem_stall_req", 32'(mem_stall_req), 32'(mem_req && !due_mem));
    if (!rdy) chk("ram_wr_gated", 32'(ram_wr), 32'd0);
    if (ram_wr === 1'b1) begin
      if (exp_wr_q.size() == 0) chk("ram_wr_unexpected", 32'd1, 32'd0);
      else begin
        mon_w = exp_wr_q.pop_front();
        chk("wr_cycle", 32'(cyc), 32'(mon_w.due));
        chk("wr_addr", ram_a, mon_w.addr);
        chk("wr_byte", 32'(ram_dout), 32'(mon_w.data));
      end
    end
    if (if_done === 1'b1) begin
      if (exp_if_q.size() == 0) chk("if_done_unexpected", 32'd1, 32'd0);
      else begin
        mon_d = exp_if_q.pop_front();
        chk("if_done_cycle", 32'(cyc), 32'(mon_d.due));
        if (mon_d.has_data) chk("if_data", if_data, mon_d.data);
      end
    end
    if (mem_done === 1'b1) begin
      if (exp_mem_q.size() == 0) chk("mem_done_unexpected", 32'd1, 32'd0);
      else begin
        mon_d = exp_mem_q.pop_front();
        chk("mem_done_cycle", 32'(cyc), 32'(mon_d.due));
        if (mon_d.has_data) chk("mem_rdata", mem_rdata, mon_d.data);
      end
    end
  end

  task automatic step_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic neg_at(input int c);
    do @(negedge clk); while (cyc < c);
    chk("sample_sync", 32'(cyc), 32'(c));
  endtask

  task automatic push_if(input logic [31:0] data, input int due);
    done_t e;
    e.data = data; e.due = due; e.has_data = 1'b1;
    exp_if_q.push_back(e);
  endtask

  task automatic push_mem(input logic [31:0] data, input int due, input bit has_data);
    done_t e;
    e.data = data; e.due = due; e.has_data = has_data;
    exp_mem_q.push_back(e);
  endtask

  task automatic push_wr(input logic [31:0] addr, input logic [7:0] data, input int due);
    wr_t w;
    w.addr = addr; w.data = data; w.due = due;
    exp_wr_q.push_back(w);
  endtask

  task automatic raise_mem(input bit we, input logic [31:0] addr, input logic [1:0] len,
                           input logic [31:0] wdata);
    mem_we = we; mem_addr = addr; mem_len = len; mem_wdata = wdata; mem_req = 1'b1;
  endtask

  // Each requester drops its request right after the edge that ends its done cycle.
  task automatic wait_done(input int budget);
    int  k = 0;
    bit  fi, fm;
    while ((if_req || mem_req) && k < budget) begin
      @(negedge clk);
      k++;
      fi = (if_done === 1'b1);
      fm = (mem_done === 1'b1);
      @(posedge clk);
      #1;
      if (fi) if_req = 1'b0;
      if (fm) mem_req = 1'b0;
    end
    if (if_req || mem_req) begin
      chk("done_timeout", 32'd1, 32'd0);
      if_req = 1'b0;
      mem_req = 1'b0;
    end
  endtask

  task automatic check_idle(input string pfx);
    chk({pfx, "_if_data"}, if_data, 32'd0);
    chk({pfx, "_mem_rdata"}, mem_rdata, 32'd0);
    chk({pfx, "_if_done"}, 32'(if_done), 32'd0);
    chk({pfx, "_mem_done"}, 32'(mem_done), 32'd0);
    chk({pfx, "_ram_wr"}, 32'(ram_wr), 32'd0);
    chk({pfx, "_ram_a"}, ram_a, 32'd0);
    chk({pfx, "_ram_dout"}, 32'(ram_dout), 32'd0);
    chk({pfx, "_if_stall"}, 32'(if_stall_req), 32'd0);
    chk({pfx, "_mem_stall"}, 32'(mem_stall_req), 32'd0);
  endtask

  initial begin
    int c0;
    rst = 1'b1; rdy = 1'b1;
    if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_len = '0; mem_wdata = '0;
    step_to(2);
    @(negedge clk);
    check_idle("reset");
    step_to(3);
    rst = 1'b0;
    step_to(5);

    // Word fetch at 0x100.
    c0 = cyc;
    if_addr = 32'h100; if_req = 1'b1;
    push_if(32'h9300_0013, c0 + 6);
    for (int i = 0; i < 4; i++) begin
      neg_at(c0 + 1 + i);
      chk("fetch_addr", ram_a, 32'h100 + 32'(i));
    end
    wait_done(40);

    // Word store 0xDEADBEEF to 0x20.
    c0 = cyc;
    raise_mem(1'b1, 32'h20, 2'd3, 32'hDEAD_BEEF);
    push_wr(32'h20, 8'hEF, c0 + 1);
    push_wr(32'h21, 8'hBE, c0 + 2);
    push_wr(32'h22, 8'hAD, c0 + 3);
    push_wr(32'h23, 8'hDE, c0 + 4);
    push_mem(32'h0, c0 + 5, 1'b0);
    wait_done(40);

    // Fetch and byte load raised together: MEM first, fetch after the done cycle.
    c0 = cyc;
    raise_mem(1'b0, 32'h40, 2'd0, 32'h0);
    if_addr = 32'h100; if_req = 1'b1;
    push_mem(32'h0000_005A, c0 + 3, 1'b1);
    push_if(32'h9300_0013, c0 + 10);
    wait_done(60);

    // Halfword store with rdy low for one cycle at cnt=1.
    c0 = cyc;
    raise_mem(1'b1, 32'h80, 2'd1, 32'hCAFE_1234);
    push_wr(32'h80, 8'h34, c0 + 1);
    push_wr(32'h81, 8'h12, c0 + 3);
    push_mem(32'h0, c0 + 4, 1'b0);
    step_to(c0 + 2);
    rdy = 1'b0;
    step_to(c0 + 3);
    rdy = 1'b1;
    wait_done(40);

    // Word load back from 0x20.
    c0 = cyc;
    raise_mem(1'b0, 32'h20, 2'd3, 32'h0);
    push_mem(32'hDEAD_BEEF, c0 + 6, 1'b1);
    wait_done(40);

    // Halfword load wrapping past 0xFFFFFFFF; upper bytes must be zero.
    c0 = cyc;
    raise_mem(1'b0, 32'hFFFF_FFFF, 2'd1, 32'h0);
    push_mem(32'h0000_ABCD, c0 + 4, 1'b1);
    neg_at(c0 + 1);
    chk("wrap_addr0", ram_a, 32'hFFFF_FFFF);
    neg_at(c0 + 2);
    chk("wrap_addr1", ram_a, 32'h0000_0000);
    wait_done(40);

    // Word fetch with rdy low for 3 cycles at cnt=2.
    c0 = cyc;
    if_addr = 32'h100; if_req = 1'b1;
    push_if(32'h9300_0013, c0 + 9);
    step_to(c0 + 3);
    rdy = 1'b0;
    step_to(c0 + 6);
    rdy = 1'b1;
    wait_done(40);

    // Reset during the cnt=1 cycle of a word store.
    c0 = cyc;
    raise_mem(1'b1, 32'h60, 2'd3, 32'h1122_3344);
    push_wr(32'h60, 8'h44, c0 + 1);
    push_wr(32'h61, 8'h33, c0 + 2);
    step_to(c0 + 2);
    rst = 1'b1;
    mem_req = 1'b0;
    neg_at(c0 + 3);
    check_idle("midrst");
    step_to(c0 + 4);
    rst = 1'b0;
    step_to(c0 + 12);

    chk("wr_q_left", 32'(exp_wr_q.size()), 32'd0);
    chk("if_q_left", 32'(exp_if_q.size()), 32'd0);
    chk("mem_q_left", 32'(exp_mem_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

endmodule
